segmentacion_elastica: RTL and testbench
========================================

# segmentacion_elastica

Parametrised elastic pipeline-register chain: the generalised successor of the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers of the current 5-stage core. It adds the following per slot:
- a valid bit;
- a stall input;
- a flush input;
- bubble collapse (a stall does not propagate backwards through an empty slot).

It also adds valid/ready handshakes at both ends and saturating performance counters. It sits between the core's stage logic: each slot carries one stage's packed control+data word, and hazard logic drives STALL/FLUSH.

## Interface
- WIDTH, 32, payload bits per slot
- STAGES, 4, number of register slots (≥2); slot 0 is youngest (input side), slot STAGES-1 oldest (output side)
- CNT_WIDTH, 16, width of each performance counter

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  reset: asynchronous assert, active-low
- IN_VALID  in  1  upstream offers IN_DATA
- IN_DATA  in  WIDTH  incoming payload
- IN_READY  out  1  slot 0 can accept this cycle
- STALL  in  STAGES  bit k holds slot k
- FLUSH  in  STAGES  bit k kills slot k
- OUT_VALID  out  1  oldest slot presents a live item
- OUT_DATA  out  WIDTH  payload of slot STAGES-1
- OUT_READY  in  1  downstream accepts
- VALID_VEC  out  STAGES  per-slot valid bits (registered)
- STAGE_DATA  out  STAGES*WIDTH  all slot payloads, slot k at bits [k*WIDTH +: WIDTH]
- OCC  out  $clog2(STAGES+1)  number of valid slots
- IN_STALL_CNT  out  CNT_WIDTH  cycles with IN_VALID=1 and IN_READY=0
- DROP_CNT  out  CNT_WIDTH  valid items killed by FLUSH

## Operation
Per-slot definitions (k = STAGES-1 is the last slot):
- live[k] = valid[k] & ~FLUSH[k]
- adv[k] = ~STALL[k] & (k==last ? OUT_READY : acc[k+1])
- acc[k] = ~valid[k] | adv[k] | FLUSH[k]. A flushed slot always accepts; the item it accepts is then dropped.
- move[k] = live[k] & adv[k]: the item leaves slot k this edge.
- in[k] = (k==0 ? IN_VALID & acc[0] : move[k-1]): an item enters slot k this edge.

Next-state rules:
- valid[k] ← FLUSH[k] ? 0 : (in[k] | (valid[k] & ~move[k]))
- Payload register k loads on in[k] & ~FLUSH[k]; otherwise it holds. Payloads of empty slots are don't-care but stable.

Outputs:
- IN_READY = acc[0]; OUT_VALID = live[last]; OUT_DATA = payload[last]. The ready chain is combinational, last slot to first.
- Ordering is strict FIFO. No item is duplicated or lost except by FLUSH.
- Bubble collapse: if STALL[j]=1 and slot j-1 is empty, the slots younger than the bubble still advance into it.

Performance counters:
- OCC = popcount(VALID_VEC), combinational from the registers.
- IN_STALL_CNT increments when IN_VALID & ~IN_READY.
- DROP_CNT increments by popcount(valid & FLUSH).
- Both counters saturate at 2^CNT_WIDTH-1 and never wrap.

## Timing
- Reset (RESET=0): immediately and asynchronously clears valid[*], payload[*], IN_STALL_CNT and DROP_CNT.
  - Outputs during reset: VALID_VEC=0, OUT_VALID=0, OUT_DATA=0, STAGE_DATA=0, OCC=0, IN_READY=1 (only if FLUSH/STALL permit; with an empty chain acc=1).
- Reset mid-operation discards all in-flight items; the counters do not count them.
- Latency:
  - An item handshaken at IN in cycle n is in slot 0 in cycle n+1.
  - With no stalls, OUT_VALID=1 in cycle n+STAGES.
- Throughput: 1 item/cycle when unstalled.
- Full chain with OUT_READY=0:
  - IN_READY=0.
  - If OUT_READY rises in cycle m, IN_READY=1 in the same cycle m (pass-through ready).
- Simultaneous events, same slot:
  - FLUSH wins over STALL.
  - FLUSH wins over an arriving item.
  - FLUSH[last]=1 forces OUT_VALID=0 that cycle, even with OUT_READY=1.
- Flushing slot k does not affect slots ≠ k. Callers flush younger stages as a contiguous mask.
- IN_DATA is captured only on IN_VALID & IN_READY. IN_VALID may drop without a handshake.

## Test plan
- **Streaming** (STAGES=4, WIDTH=32): feed 1..10 with IN_VALID=1, OUT_READY=1 → first OUT_VALID 4 cycles after the first handshake, OUT_DATA=1..10 on consecutive cycles, IN_STALL_CNT=0.
- **Backpressure**: OUT_READY=0 while IN_VALID=1 for 6 cycles → items 1–4 accepted, OCC=4, IN_READY=0 for cycles 5–6, IN_STALL_CNT=2. Then OUT_READY=1 → OUT_DATA=1,2,3,4,5,… with no gap.
- **Bubble collapse**:
  - Setup: slots hold {A,–,B,C} (slot0..3); STALL=4'b1000, OUT_READY=1.
  - Next cycle: C stays in slot 3, B stays in slot 2 (its successor is blocked), A moves to slot 1, and the new input enters slot 0.
- **Flush**:
  - Setup: full chain {D,C,B,A}; FLUSH=4'b0011 for one cycle with OUT_READY=1.
  - Next cycle: slot 0 is empty (the accepted input was killed), slot 1 is empty, B is in slot 3, DROP_CNT=2.
  - Outputs then emit A, then B only.
- **Async reset**: RESET→0 between edges with 3 items in flight → VALID_VEC=0, OUT_VALID=0, OCC=0 before the next edge. After RESET→1, the next input emerges with 4-cycle latency.
- **Counter saturation** (CNT_WIDTH=4): hold IN_VALID=1, OUT_READY=0 for 30 cycles → IN_STALL_CNT=15 and it stays at 15.

Source files
------------

// File: rtl/segmentacion_elastica.sv
// Elastic chain of STAGES pipeline slots with per-slot valid, stall, flush and bubble collapse.
// Latency: an accepted item reaches the output slot after STAGES cycles when nothing is stalled.
// Backpressure: ready ripples combinationally from OUT_READY back to IN_READY; empty or flushed slots absorb stalls.
module segmentacion_elastica #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         IN_VALID,
    input  logic [WIDTH-1:0]             IN_DATA,
    output logic                         IN_READY,
    input  logic [STAGES-1:0]            STALL,
    input  logic [STAGES-1:0]            FLUSH,
    output logic                         OUT_VALID,
    output logic [WIDTH-1:0]             OUT_DATA,
    input  logic                         OUT_READY,
    output logic [STAGES-1:0]            VALID_VEC,
    output logic [STAGES*WIDTH-1:0]      STAGE_DATA,
    output logic [$clog2(STAGES+1)-1:0]  OCC,
    output logic [CNT_WIDTH-1:0]         IN_STALL_CNT,
    output logic [CNT_WIDTH-1:0]         DROP_CNT
);
    localparam int LAST  = STAGES - 1;
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int SUM_W = ((CNT_WIDTH > OCC_W) ? CNT_WIDTH : OCC_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  payload_q [STAGES];

    logic [STAGES-1:0] live, adv, acc, move, ins, valid_d;
    logic [OCC_W-1:0]  occ_c, drop_pop;
    logic [SUM_W-1:0]  stall_sum, drop_sum;
    logic [CNT_WIDTH-1:0] in_stall_cnt_q, drop_cnt_q;
    logic              in_stall_inc;

    // Ready walks from the output slot towards slot 0; a slot accepts when empty, leaving or being killed.
    always_comb begin : ready_chain
        logic rdy;
        rdy = OUT_READY;
        adv = '0;
        acc = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = ~STALL[k] & rdy;
            acc[k] = ~valid_q[k] | adv[k] | FLUSH[k];
            rdy    = acc[k];
        end
    end

    assign live    = valid_q & ~FLUSH;
    assign move    = live & adv;
    assign ins     = {move[LAST-1:0], IN_VALID & acc[0]};
    assign valid_d = ~FLUSH & (ins | (valid_q & ~move));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payloads only move with a surviving item, so empty slots keep a stable stale value.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < STAGES; k++) begin
                payload_q[k] <= '0;
            end
        end else begin
            if (ins[0] & ~FLUSH[0]) begin
                payload_q[0] <= IN_DATA;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ins[k] & ~FLUSH[k]) begin
                    payload_q[k] <= payload_q[k-1];
                end
            end
        end
    end

    always_comb begin
        occ_c    = '0;
        drop_pop = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_c    = occ_c + OCC_W'(valid_q[k]);
            drop_pop = drop_pop + OCC_W'(valid_q[k] & FLUSH[k]);
        end
    end

    assign in_stall_inc = IN_VALID & ~acc[0];
    assign stall_sum    = SUM_W'(in_stall_cnt_q) + SUM_W'(in_stall_inc);
    assign drop_sum     = SUM_W'(drop_cnt_q) + SUM_W'(drop_pop);

    // Counters clamp at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            in_stall_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            if (stall_sum > SUM_W'(CNT_MAX)) begin
                in_stall_cnt_q <= CNT_MAX;
            end else begin
                in_stall_cnt_q <= stall_sum[CNT_WIDTH-1:0];
            end
            if (drop_sum > SUM_W'(CNT_MAX)) begin
                drop_cnt_q <= CNT_MAX;
            end else begin
                drop_cnt_q <= drop_sum[CNT_WIDTH-1:0];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage_data
        assign STAGE_DATA[g*WIDTH +: WIDTH] = payload_q[g];
    end

    assign IN_READY     = acc[0];
    assign OUT_VALID    = live[LAST];
    assign OUT_DATA     = payload_q[LAST];
    assign VALID_VEC    = valid_q;
    assign OCC          = occ_c;
    assign IN_STALL_CNT = in_stall_cnt_q;
    assign DROP_CNT     = drop_cnt_q;
endmodule

// File: tb/tb_segmentacion_elastica.sv
// Bench for segmentacion_elastica: directed scenarios plus a random run against a slot-occupancy model.
module tb_segmentacion_elastica;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           IN_VALID;
    logic [W-1:0]   IN_DATA;
    logic           IN_READY;
    logic [S-1:0]   STALL;
    logic [S-1:0]   FLUSH;
    logic           OUT_VALID;
    logic [W-1:0]   OUT_DATA;
    logic           OUT_READY;
    logic [S-1:0]   VALID_VEC;
    logic [S*W-1:0] STAGE_DATA;
    logic [$clog2(S+1)-1:0] OCC;
    logic [CW-1:0]  IN_STALL_CNT;
    logic [CW-1:0]  DROP_CNT;

    segmentacion_elastica #(.WIDTH(W), .STAGES(S), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
        .OUT_READY(OUT_READY), .VALID_VEC(VALID_VEC), .STAGE_DATA(STAGE_DATA), .OCC(OCC),
        .IN_STALL_CNT(IN_STALL_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: which slots hold an item and what it is, plus the two counters.
    bit         m_vld [S];
    logic [W-1:0] m_dat [S];
    int         m_stall_cnt;
    int         m_drop_cnt;
    logic [W-1:0] out_q [$];
    int         out_cyc [$];
    int         in_cyc [$];
    bit         last_in_rdy;
    bit         last_hs;
    logic [W-1:0] nxt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            m_vld[k] = 1'b0;
            m_dat[k] = '0;
        end
        m_stall_cnt = 0;
        m_drop_cnt  = 0;
    endtask

    // Called right after a falling edge with inputs already driven; ends at the next falling edge.
    task automatic cycle();
        bit space;
        bit go [S];
        bit free [S];
        bit nv [S];
        logic [W-1:0] nd [S];
        bit ov;
        int occ;
        int drops;
        logic [S-1:0] vv;
        #1;
        space = OUT_READY;
        for (int k = S - 1; k >= 0; k--) begin
            go[k]   = !STALL[k] && space;
            free[k] = !m_vld[k] || go[k] || FLUSH[k];
            space   = free[k];
        end
        ov  = m_vld[S-1] && !FLUSH[S-1];
        occ = 0;
        vv  = '0;
        for (int k = 0; k < S; k++) begin
            occ   += int'(m_vld[k]);
            vv[k] = m_vld[k];
        end
        chk("in_ready", IN_READY, free[0]);
        chk("out_valid", OUT_VALID, ov);
        if (ov) chk("out_data", OUT_DATA, m_dat[S-1]);
        chk("valid_vec", VALID_VEC, vv);
        chk("occ", OCC, occ);
        chk("in_stall_cnt", IN_STALL_CNT, m_stall_cnt);
        chk("drop_cnt", DROP_CNT, m_drop_cnt);
        for (int k = 0; k < S; k++) begin
            if (m_vld[k]) chk("stage_data", STAGE_DATA[k*W +: W], m_dat[k]);
        end
        last_in_rdy = IN_READY;
        last_hs     = IN_VALID && free[0];

        drops = 0;
        for (int k = 0; k < S; k++) begin
            nv[k] = 1'b0;
            nd[k] = m_dat[k];
        end
        for (int k = 0; k < S; k++) begin
            if (m_vld[k] && FLUSH[k]) drops++;
            if (m_vld[k] && !FLUSH[k]) begin
                if (!go[k]) begin
                    nv[k] = 1'b1;
                    nd[k] = m_dat[k];
                end else if (k == S - 1) begin
                    out_q.push_back(m_dat[k]);
                    out_cyc.push_back(cyc);
                end else if (!FLUSH[k+1]) begin
                    nv[k+1] = 1'b1;
                    nd[k+1] = m_dat[k];
                end
            end
        end
        if (last_hs) begin
            in_cyc.push_back(cyc);
            if (!FLUSH[0]) begin
                nv[0] = 1'b1;
                nd[0] = IN_DATA;
            end
        end
        if (IN_VALID && !free[0]) m_stall_cnt = (m_stall_cnt + 1 > SAT) ? SAT : m_stall_cnt + 1;
        m_drop_cnt = (m_drop_cnt + drops > SAT) ? SAT : m_drop_cnt + drops;
        @(posedge CLK);
        for (int k = 0; k < S; k++) begin
            m_vld[k] = nv[k];
            m_dat[k] = nd[k];
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic quiet();
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        STALL     = '0;
        FLUSH     = '0;
        OUT_READY = 1'b1;
    endtask

    task automatic do_reset();
        quiet();
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        model_reset();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic push(input logic [W-1:0] d);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        cycle();
        IN_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        quiet();
        model_reset();
        #2;
        chk("rst_valid_vec", VALID_VEC, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_data", OUT_DATA, 0);
        chk("rst_occ", OCC, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_stall_cnt", IN_STALL_CNT, 0);
        chk("rst_drop_cnt", DROP_CNT, 0);
        for (int k = 0; k < S; k++) chk("rst_stage_data", STAGE_DATA[k*W +: W], 0);
        @(negedge CLK);
        RESET = 1'b1;

        // Streaming 1..10
        do_reset();
        for (int i = 1; i <= 10; i++) push(W'(i));
        for (int i = 0; i < 6; i++) cycle();
        chk("stream_count", out_q.size(), 10);
        chk("stream_latency", out_cyc[0] - in_cyc[0], S);
        for (int i = 0; i < out_q.size(); i++) begin
            chk("stream_data", out_q[i], i + 1);
            chk("stream_back_to_back", out_cyc[i] - out_cyc[0], i);
        end
        chk("stream_stall_cnt", IN_STALL_CNT, 0);

        // Backpressure with pass-through ready
        do_reset();
        OUT_READY = 1'b0;
        nxt = 1;
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = nxt;
            cycle();
            chk("bp_in_ready", last_in_rdy, i < 4);
            if (last_hs) nxt++;
        end
        chk("bp_occ", OCC, 4);
        chk("bp_stall_cnt", IN_STALL_CNT, 2);
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            IN_DATA = nxt;
            cycle();
            if (i == 0) chk("bp_pass_through_ready", last_in_rdy, 1);
            if (last_hs) nxt++;
        end
        IN_VALID = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_count", out_q.size(), 12);
        for (int i = 0; i < out_q.size(); i++) begin
            chk("bp_data", out_q[i], i + 1);
            chk("bp_no_gap", out_cyc[i] - out_cyc[0], i);
        end

        // Bubble collapse: build {A,-,B,C}
        do_reset();
        OUT_READY = 1'b0;
        push(32'hC);
        push(32'hB);
        cycle();
        push(32'hA);
        chk("bub_setup_vv", VALID_VEC, 4'b1101);
        STALL     = 4'b1000;
        OUT_READY = 1'b1;
        push(32'hE);
        STALL = '0;
        chk("bub_vv", VALID_VEC, 4'b1111);
        chk("bub_slot3", STAGE_DATA[3*W +: W], 32'hC);
        chk("bub_slot2", STAGE_DATA[2*W +: W], 32'hB);
        chk("bub_slot1", STAGE_DATA[1*W +: W], 32'hA);
        chk("bub_slot0", STAGE_DATA[0*W +: W], 32'hE);

        // Flush of the two youngest slots
        do_reset();
        OUT_READY = 1'b0;
        push(32'hA1);
        push(32'hB2);
        push(32'hC3);
        push(32'hD4);
        out_q.delete();
        FLUSH     = 4'b0011;
        OUT_READY = 1'b1;
        push(32'hF5);
        FLUSH = '0;
        chk("flush_vv", VALID_VEC, 4'b1000);
        chk("flush_slot3", STAGE_DATA[3*W +: W], 32'hB2);
        chk("flush_drop_cnt", DROP_CNT, 2);
        for (int i = 0; i < 4; i++) cycle();
        chk("flush_count", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("flush_out0", out_q[0], 32'hA1);
            chk("flush_out1", out_q[1], 32'hB2);
        end

        // Asynchronous reset with items in flight
        do_reset();
        push(32'h11);
        push(32'h22);
        push(32'h33);
        RESET = 1'b0;
        #1;
        chk("arst_valid_vec", VALID_VEC, 0);
        chk("arst_out_valid", OUT_VALID, 0);
        chk("arst_occ", OCC, 0);
        chk("arst_drop_cnt", DROP_CNT, 0);
        chk("arst_in_ready", IN_READY, 1);
        #1;
        RESET = 1'b1;
        model_reset();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
        @(negedge CLK);
        push(32'h44);
        for (int i = 0; i < 5; i++) cycle();
        chk("arst_count", out_q.size(), 1);
        if (out_q.size() == 1) begin
            chk("arst_data", out_q[0], 32'h44);
            chk("arst_latency", out_cyc[0] - in_cyc[0], S);
        end

        // Stall counter saturation
        do_reset();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 32'h5A;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (i == 20) chk("sat_reached", IN_STALL_CNT, SAT);
        end
        chk("sat_held", IN_STALL_CNT, SAT);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            IN_VALID  = ($urandom % 4) != 0;
            IN_DATA   = $urandom;
            OUT_READY = ($urandom % 4) != 0;
            for (int k = 0; k < S; k++) STALL[k] = ($urandom % 6) == 0;
            if ($urandom % 12 == 0) FLUSH = S'((1 << $urandom_range(1, S)) - 1);
            else FLUSH = '0;
            cycle();
        end
        quiet();
        for (int i = 0; i < 6; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
